// File: rtl/cart_bus_master.sv
// Cartridge bus initiator: turns single-word host requests into timed ROM/TIME cycles.
// Optional build macro CART_BUS_DOUBLE_SAMPLE_EN adds an early read sample to flag marginal ROM timing.
module cart_bus_master #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 6,
    parameter int HOLD_CYC   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_space,
    input  logic [23:1] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [23:1] cart_address,
    output logic [15:0] cart_data_o,
    output logic        cart_data_oe,
    input  logic [15:0] cart_data_i,
    output logic        ce_0,
    output logic        cas0,
    output logic        lwr,
    output logic        tme
);

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             wr_q;
    logic [15:0]      sample_q;
    logic             sample_bad;
    logic             range_bad;
    logic             cnt_zero;

    // ROM space is only $000000-$3FFFFF; TIME space addresses pass unchecked.
    assign range_bad = ~req_space & (req_addr[23:22] != 2'b00);
    assign cnt_zero  = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (req_valid && !range_bad) state_next = SETUP;
            SETUP:   if (cnt_zero) state_next = STROBE;
            STROBE:  if (cnt_zero) state_next = HOLD;
            HOLD:    if (cnt_zero) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            wr_q         <= 1'b0;
            sample_q     <= '0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            cart_address <= '0;
            cart_data_o  <= '0;
            cart_data_oe <= 1'b0;
            ce_0         <= 1'b1;
            cas0         <= 1'b1;
            lwr          <= 1'b1;
            tme          <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (range_bad) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            req_ready    <= 1'b0;
                            wr_q         <= req_write;
                            cart_address <= req_addr;
                            cnt          <= CNT_W'(SETUP_CYC - 1);
                            if (req_space) tme  <= 1'b0;
                            else           ce_0 <= 1'b0;
                            if (req_write) begin
                                cart_data_oe <= 1'b1;
                                cart_data_o  <= req_wdata;
                            end
                        end
                    end
                end
                SETUP: begin
                    if (cnt_zero) begin
                        cnt <= CNT_W'(STROBE_CYC - 1);
                        if (wr_q) lwr  <= 1'b0;
                        else      cas0 <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt_zero) begin
                        cnt  <= CNT_W'(HOLD_CYC - 1);
                        cas0 <= 1'b1;
                        lwr  <= 1'b1;
                        if (!wr_q) sample_q <= cart_data_i;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_zero) begin
                        ce_0         <= 1'b1;
                        tme          <= 1'b1;
                        cart_data_oe <= 1'b0;
                        req_ready    <= 1'b1;
                        rsp_valid    <= 1'b1;
                        rsp_err      <= sample_bad;
                        if (!wr_q) rsp_rdata <= sample_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CART_BUS_DOUBLE_SAMPLE_EN
    logic [15:0] early_q;

    // Early sample on the second-to-last strobe clock, compared against the final one.
    always_ff @(posedge clk) begin
        if (rst) begin
            early_q    <= '0;
            sample_bad <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            sample_bad <= 1'b0;
        end else if (state == STROBE && !wr_q) begin
            if (cnt == CNT_W'(1)) early_q <= cart_data_i;
            if (cnt_zero)         sample_bad <= (early_q != cart_data_i);
        end
    end
`else
    assign sample_bad = 1'b0;
`endif

endmodule

// File: tb/tb_cart_bus_master.sv
// Directed bench for cart_bus_master: scoreboarded responses, strobe timing counters and a bank mapper model.
module tb_cart_bus_master;

    localparam int SETUP_CYC  = 2;
    localparam int STROBE_CYC = 6;
    localparam int HOLD_CYC   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_space;
    logic [23:1] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [23:1] cart_address;
    logic [15:0] cart_data_o;
    logic        cart_data_oe;
    logic [15:0] cart_data_i;
    logic        ce_0, cas0, lwr, tme;

    cart_bus_master #(
        .SETUP_CYC (SETUP_CYC),
        .STROBE_CYC(STROBE_CYC),
        .HOLD_CYC  (HOLD_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_space(req_space), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cart_address(cart_address), .cart_data_o(cart_data_o), .cart_data_oe(cart_data_oe),
        .cart_data_i(cart_data_i),
        .ce_0(ce_0), .cas0(cas0), .lwr(lwr), .tme(tme)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [16:0] exp_q[$];
    logic [15:0] exp_rdata;
    logic        exp_err;
    logic [15:0] bank [8];

    int acc_n, acc_cyc, acc_first, rsp_n, rsp_cyc, rsp_first;
    int ce_lo, cas_lo, lwr_lo, tme_lo, oe_hi, oe_pre;
    int cas_fall, cas_rise_first, lwr_fall;
    logic prev_cas, prev_lwr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        acc_n = 0; acc_cyc = -1; acc_first = -1;
        rsp_n = 0; rsp_cyc = -1; rsp_first = -1;
        ce_lo = 0; cas_lo = 0; lwr_lo = 0; tme_lo = 0; oe_hi = 0; oe_pre = 0;
        cas_fall = -1; cas_rise_first = -1; lwr_fall = -1;
    endtask

    // One clock; observes the DUT 1 time unit after the edge.
    task automatic tick();
        logic go;
        logic [16:0] e;
        go = req_valid && req_ready && !rst;
        @(posedge clk);
        #1;
        cyc++;
        if (go) begin
            exp_q.push_back({exp_rdata, exp_err});
            acc_n++;
            acc_cyc = cyc;
            if (acc_first < 0) acc_first = cyc;
        end
        check("inv_cas_lwr", {31'd0, ~(~cas0 & ~lwr)}, 32'd1);
        check("inv_ce_tme", {31'd0, ~(~ce_0 & ~tme)}, 32'd1);
        if (!ce_0) ce_lo++;
        if (!cas0) cas_lo++;
        if (!lwr)  lwr_lo++;
        if (!tme)  tme_lo++;
        if (cart_data_oe) oe_hi++;
        if (cart_data_oe && lwr && lwr_lo == 0) oe_pre++;
        if (prev_cas && !cas0) cas_fall = cyc;
        if (!prev_cas && cas0 && cas_rise_first < 0) cas_rise_first = cyc;
        if (prev_lwr && !lwr) begin
            lwr_fall = cyc;
            if (!tme) bank[cart_address[3:1]] = cart_data_o;
        end
        prev_cas = cas0;
        prev_lwr = lwr;
        if (rsp_valid) begin
            rsp_n++;
            rsp_cyc = cyc;
            if (rsp_first < 0) rsp_first = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e[16:1]});
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e[0]});
            end
        end
    endtask

    task automatic start_req(input logic w, input logic s, input logic [23:0] ba,
                             input logic [15:0] wd, input logic [15:0] er, input logic ee);
        int n0;
        int guard;
        req_write = w;
        req_space = s;
        req_addr  = ba[23:1];
        req_wdata = wd;
        exp_rdata = er;
        exp_err   = ee;
        req_valid = 1'b1;
        n0 = acc_n;
        guard = 0;
        while (acc_n == n0 && guard < 30) begin
            tick();
            guard++;
        end
        if (acc_n == n0) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input int n);
        int guard;
        guard = 0;
        while (rsp_n < n && guard < 50) begin
            tick();
            guard++;
        end
        if (rsp_n < n) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int guard;
        int n_before;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_space = 1'b0;
        req_addr = '0; req_wdata = '0; cart_data_i = '0;
        exp_rdata = '0; exp_err = 1'b0;
        prev_cas = 1'b1; prev_lwr = 1'b1;
        for (int i = 0; i < 8; i++) bank[i] = '0;
        clr();
        repeat (3) tick();

        check("rst_ce_0", {31'd0, ce_0}, 32'd1);
        check("rst_cas0", {31'd0, cas0}, 32'd1);
        check("rst_lwr", {31'd0, lwr}, 32'd1);
        check("rst_tme", {31'd0, tme}, 32'd1);
        check("rst_oe", {31'd0, cart_data_oe}, 32'd0);
        check("rst_addr", {9'd0, cart_address}, 32'd0);
        check("rst_data_o", {16'd0, cart_data_o}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        rst = 1'b0;
        tick();

        // ROM read at $040000
        clr();
        cart_data_i = 16'hBEEF;
        start_req(1'b0, 1'b0, 24'h040000, 16'h0000, 16'hBEEF, 1'b0);
        req_valid = 1'b0;
        check("rd_addr", {9'd0, cart_address}, {9'd0, 23'h020000});
        check("rd_ready_busy", {31'd0, req_ready}, 32'd0);
        wait_rsp(1);
        check("rd_latency", rsp_cyc - acc_cyc, SETUP_CYC + STROBE_CYC + HOLD_CYC);
        check("rd_ce_lo", ce_lo, 10);
        check("rd_cas_lo", cas_lo, STROBE_CYC);
        check("rd_cas_start", cas_fall - acc_cyc, SETUP_CYC);
        check("rd_lwr_lo", lwr_lo, 0);
        check("rd_tme_lo", tme_lo, 0);
        check("rd_oe_hi", oe_hi, 0);
        check("rd_ready_at_rsp", {31'd0, req_ready}, 32'd1);

        // TIME write: bank register 1 at $A130F3
        clr();
        start_req(1'b1, 1'b1, 24'hA130F3, 16'h0005, 16'hBEEF, 1'b0);
        req_valid = 1'b0;
        wait_rsp(1);
        check("wr_latency", rsp_cyc - acc_cyc, 10);
        check("wr_tme_lo", tme_lo, 10);
        check("wr_ce_lo", ce_lo, 0);
        check("wr_cas_lo", cas_lo, 0);
        check("wr_lwr_lo", lwr_lo, STROBE_CYC);
        check("wr_oe_pre", oe_pre, SETUP_CYC);
        check("wr_lwr_start", lwr_fall - acc_cyc, SETUP_CYC);
        check("wr_oe_hi", oe_hi, 10);
        check("wr_bank1", {16'd0, bank[1]}, 32'h0005);
        check("wr_oe_after", {31'd0, cart_data_oe}, 32'd0);

        // ROM read out of range: rejected with no bus activity
        clr();
        start_req(1'b0, 1'b0, 24'h400000, 16'h0000, 16'hBEEF, 1'b1);
        req_valid = 1'b0;
        check("rej_rsp_now", {31'd0, rsp_valid}, 32'd1);
        check("rej_rsp_cyc", rsp_cyc, acc_cyc);
        repeat (4) tick();
        check("rej_rsp_n", rsp_n, 1);
        check("rej_strobes", ce_lo + cas_lo + lwr_lo + tme_lo + oe_hi, 0);
        check("rej_ready", {31'd0, req_ready}, 32'd1);

        // Back-to-back reads with req_valid held high
        clr();
        cart_data_i = 16'hA5A5;
        req_write = 1'b0; req_space = 1'b0; req_addr = 23'h000010; req_wdata = '0;
        exp_rdata = 16'hA5A5; exp_err = 1'b0;
        req_valid = 1'b1;
        guard = 0;
        while (acc_n < 2 && guard < 40) begin
            tick();
            if (rsp_n >= 1) begin
                cart_data_i = 16'h5A5A;
                exp_rdata = 16'h5A5A;
            end
            guard++;
        end
        req_valid = 1'b0;
        check("b2b_accepts", acc_n, 2);
        wait_rsp(2);
        check("b2b_acc_after_rsp", acc_cyc - rsp_first, 1);
        // gap = HOLD + the shared rsp/accept cycle + SETUP
        check("b2b_strobe_gap", cas_fall - cas_rise_first, HOLD_CYC + 1 + SETUP_CYC);
        check("b2b_cas_lo", cas_lo, 2 * STROBE_CYC);

        // Reset during the STROBE phase of a write
        clr();
        start_req(1'b1, 1'b1, 24'hA130F5, 16'h0007, 16'h5A5A, 1'b0);
        req_valid = 1'b0;
        guard = 0;
        while (lwr && guard < 20) begin
            tick();
            guard++;
        end
        check("mid_lwr_low", {31'd0, lwr}, 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        exp_q.delete();
        check("mid_lwr", {31'd0, lwr}, 32'd1);
        check("mid_tme", {31'd0, tme}, 32'd1);
        check("mid_oe", {31'd0, cart_data_oe}, 32'd0);
        check("mid_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b0;
        n_before = rsp_n;
        repeat (15) tick();
        check("mid_no_rsp", rsp_n, n_before);

        // Read whose data changes on the last strobe clock
        clr();
        cart_data_i = 16'h1234;
`ifdef CART_BUS_DOUBLE_SAMPLE_EN
        start_req(1'b0, 1'b0, 24'h000200, 16'h0000, 16'h1235, 1'b1);
`else
        start_req(1'b0, 1'b0, 24'h000200, 16'h0000, 16'h1235, 1'b0);
`endif
        req_valid = 1'b0;
        guard = 0;
        while (cyc < acc_cyc + SETUP_CYC + STROBE_CYC - 1 && guard < 20) begin
            tick();
            guard++;
        end
        cart_data_i = 16'h1235;
        wait_rsp(1);
        check("ds_latency", rsp_cyc - acc_cyc, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
